// File: rtl/alu_rr_scheduler_if.sv
// Handshake bundle between two ALU requesters, the scheduler and the result consumer.
// Ports: req0_*/req1_* carry valid/ready plus ctrl, a and b for each requester;
//        rsp_* carry valid/ready plus the id, x and cout of the result.
// slave = scheduler side, master = requester/consumer side.
interface alu_rr_scheduler_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_ctrl;
  logic [3:0] req0_a;
  logic [3:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_ctrl;
  logic [3:0] req1_a;
  logic [3:0] req1_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_x;
  logic       rsp_cout;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_x, rsp_cout,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_x, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit ALU between two valid/ready requesters.
// Latency: accept in cycle c, rsp_valid high from cycle c+2; accepts at least 3 cycles apart.
// Backpressure: result held in RESP until rsp_ready; no request is accepted outside IDLE.
// Ports: clk, rst (sync, active-high), bus (alu_rr_scheduler_if.slave), busy (high outside IDLE).

// 4-bit ALU: add/sub produce a 5-bit result whose bit 4 is carry (add) or borrow (sub).
module alu (
  input  logic [2:0] ctrl,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] x,
  output logic       cout
);
  logic [4:0] sum;
  logic [4:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    x    = 4'd0;
    cout = 1'b0;
    case (ctrl)
      3'b000: begin x = sum[3:0]; cout = sum[4]; end
      3'b001: begin x = dif[3:0]; cout = dif[4]; end
      3'b010: x = a ^ b;
      3'b011: x = a | b;
      3'b100: x = a & b;
      3'b101: x = ~(a | b);
      3'b110: x = ~(a & b);
      3'b111: x = ~(a ^ b);
    endcase
  end
endmodule

module alu_rr_scheduler (
  input  logic                      clk,
  input  logic                      rst,
  alu_rr_scheduler_if.slave         bus,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic [2:0] op_ctrl;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_id;

  logic       gnt0;
  logic       gnt1;
  logic [3:0] alu_x;
  logic       alu_cout;

  // Grant only in IDLE; on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  alu u_alu (
    .ctrl (op_ctrl),
    .a    (op_a),
    .b    (op_b),
    .x    (alu_x),
    .cout (alu_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      op_ctrl       <= 3'd0;
      op_a          <= 4'd0;
      op_b          <= 4'd0;
      op_id         <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_x     <= 4'd0;
      bus.rsp_cout  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_id   <= gnt1;
            op_ctrl <= gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
            op_a    <= gnt1 ? bus.req1_a    : bus.req0_a;
            op_b    <= gnt1 ? bus.req1_b    : bus.req0_b;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_x     <= alu_x;
          // Carry/borrow only means something for add (000) and sub (001).
          bus.rsp_cout  <= (op_ctrl[2:1] == 2'b00) ? alu_cout : 1'b0;
          bus.rsp_id    <= op_id;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            last_grant    <= bus.rsp_id;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: vector table of single ops, then
// backpressure, reset-in-EXEC and round-robin tie sequences.
module tb_alu_rr_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  alu_rr_scheduler_if ifc ();

  alu_rr_scheduler dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [2:0] ctrl;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_x;
    logic       exp_cout;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] c,
                       input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      ifc.req1_valid = v; ifc.req1_ctrl = c; ifc.req1_a = a; ifc.req1_b = b;
    end else begin
      ifc.req0_valid = v; ifc.req0_ctrl = c; ifc.req0_a = a; ifc.req0_b = b;
    end
  endtask

  function automatic logic rdy(input logic id);
    return id ? ifc.req1_ready : ifc.req0_ready;
  endfunction

  // Samples at negedges until requester id is ready; a timeout is a failed check.
  task automatic wait_ready(input logic id, input string nm);
    int n = 0;
    @(negedge clk);
    while (!rdy(id) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(rdy(id)), 1);
  endtask

  task automatic do_op(input vec_t v);
    @(posedge clk); #1;
    drive(v.id, 1'b1, v.ctrl, v.a, v.b);
    ifc.rsp_ready = 1'b1;
    wait_ready(v.id, "accept_ready");
    chk("other_ready", int'(rdy(~v.id)), 0);
    @(posedge clk); #1;
    drive(v.id, 1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("exec_rsp_valid", int'(ifc.rsp_valid), 0);
    chk("exec_busy", int'(busy), 1);
    @(negedge clk);
    chk("rsp_valid", int'(ifc.rsp_valid), 1);
    chk("rsp_id", int'(ifc.rsp_id), int'(v.id));
    chk("rsp_x", int'(ifc.rsp_x), int'(v.exp_x));
    chk("rsp_cout", int'(ifc.rsp_cout), int'(v.exp_cout));
    @(negedge clk);
    chk("post_rsp_valid", int'(ifc.rsp_valid), 0);
    chk("post_busy", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc [4];
    int acc_id  [4];
    int nacc;

    //           id    ctrl    a      b      x        cout
    vecs[0]  = '{1'b0, 3'b000, 4'd8,  4'd1,  4'b1001, 1'b0};
    vecs[1]  = '{1'b1, 3'b001, 4'd2,  4'd3,  4'b1111, 1'b1};
    vecs[2]  = '{1'b0, 3'b000, 4'd15, 4'd1,  4'b0000, 1'b1};
    vecs[3]  = '{1'b0, 3'b110, 4'd4,  4'd5,  4'b1011, 1'b0};
    vecs[4]  = '{1'b1, 3'b111, 4'd2,  4'd3,  4'b1110, 1'b0};
    vecs[5]  = '{1'b0, 3'b101, 4'd4,  4'd5,  4'b1010, 1'b0};
    vecs[6]  = '{1'b1, 3'b010, 4'd5,  4'd3,  4'b0110, 1'b0};
    vecs[7]  = '{1'b0, 3'b011, 4'd5,  4'd8,  4'b1101, 1'b0};
    vecs[8]  = '{1'b1, 3'b100, 4'd6,  4'd3,  4'b0010, 1'b0};
    vecs[9]  = '{1'b0, 3'b001, 4'd7,  4'd2,  4'b0101, 1'b0};
    vecs[10] = '{1'b1, 3'b001, 4'd0,  4'd1,  4'b1111, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    ifc.rsp_ready = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", int'(ifc.rsp_valid), 0);
    chk("rst_rsp_x", int'(ifc.rsp_x), 0);
    chk("rst_rsp_cout", int'(ifc.rsp_cout), 0);
    chk("rst_rsp_id", int'(ifc.rsp_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req0_ready", int'(ifc.req0_ready), 0);
    chk("rst_req1_ready", int'(ifc.req1_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) do_op(vecs[i]);

    // Backpressure: hold result for 5 RESP cycles while req1 waits.
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 4'd3, 4'd4);
    wait_ready(1'b0, "bp_accept0");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 3'b100, 4'd5, 4'd6);
    @(negedge clk);
    chk("bp_exec_req1_ready", int'(ifc.req1_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", int'(ifc.rsp_valid), 1);
      chk("bp_rsp_x", int'(ifc.rsp_x), 7);
      chk("bp_rsp_id", int'(ifc.rsp_id), 0);
      chk("bp_rsp_cout", int'(ifc.rsp_cout), 0);
      chk("bp_busy", int'(busy), 1);
      chk("bp_req1_ready", int'(ifc.req1_ready), 0);
    end
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_rsp_valid", int'(ifc.rsp_valid), 1);
    chk("bp_hs_req1_ready", int'(ifc.req1_ready), 0);
    @(negedge clk);
    chk("bp_next_req1_ready", int'(ifc.req1_ready), 1);
    chk("bp_next_rsp_valid", int'(ifc.rsp_valid), 0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_req1_rsp_valid", int'(ifc.rsp_valid), 1);
    chk("bp_req1_rsp_x", int'(ifc.rsp_x), 4);
    chk("bp_req1_rsp_id", int'(ifc.rsp_id), 1);

    // Reset asserted while EXEC: op discarded, no response.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b000, 4'd5, 4'd5);
    wait_ready(1'b0, "rst_op_accept");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_busy", int'(busy), 0);
    chk("rstx_rsp_valid", int'(ifc.rsp_valid), 0);
    chk("rstx_rsp_x", int'(ifc.rsp_x), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstx_no_rsp", int'(ifc.rsp_valid), 0);
    end

    // Both valid continuously: expect grants 0,1,0,1 three cycles apart.
    nacc = 0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b000, 4'd1, 4'd1);
    drive(1'b1, 1'b1, 3'b010, 4'd1, 4'd3);
    ifc.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rr_not_both", int'(ifc.req0_ready && ifc.req1_ready), 0);
      if (ifc.req0_ready || ifc.req1_ready) begin
        if (nacc < 4) begin
          acc_cyc[nacc] = c;
          acc_id[nacc]  = int'(ifc.req1_ready);
        end
        nacc++;
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    chk("rr_accept_count", nacc, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nacc) begin
        chk("rr_grant_id", acc_id[i], i % 2);
        chk("rr_grant_cycle", acc_cyc[i], 3 * i);
      end
    end
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
